// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mmu_pkg
//  Purpose  : Shared types and constants for the mmu_tlb translation unit:
//             TLB entry layout, exception codes, segment decode constants.
//  Revision : 1.0 - initial release
// ============================================================================
package mmu_pkg;

    // Storage width of the ASID field inside an entry; ASID_W of the unit
    // must not exceed this.
    localparam int ASID_WIDTH = 8;

    localparam logic [31:0] KSEG0_BASE     = 32'h8000_0000;
    localparam logic [31:0] KSEG1_BASE     = 32'hA000_0000;
    localparam logic [2:0]  SEG_KSEG0      = 3'b100;
    localparam logic [2:0]  SEG_KSEG1      = 3'b101;
    localparam logic [2:0]  CACHE_UNCACHED = 3'd2;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_REFILL   = 2'd1,
        EXC_INVALID  = 2'd2,
        EXC_MODIFIED = 2'd3
    } mmu_exc_t;

    // One even/odd page pair, MIPS EntryHi/EntryLo0/EntryLo1 style.
    typedef struct packed {
        logic [18:0]           vpn2;
        logic [ASID_WIDTH-1:0] asid;
        logic                  g;
        logic [19:0]           pfn0;
        logic [2:0]            c0;
        logic                  d0;
        logic                  v0;
        logic [19:0]           pfn1;
        logic [2:0]            c1;
        logic                  d1;
        logic                  v1;
    } tlb_entry_t;

endpackage : mmu_pkg
`default_nettype wire

// File: rtl/tlb_match.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_match
//  Purpose  : Fully-associative tag compare across all TLB entries followed
//             by a lowest-index-wins priority encoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tlb_match #(
    parameter int ENTRIES = 16,
    parameter int ASID_W  = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [18:0]        ent_vpn2_i [ENTRIES],
    input  logic [ASID_W-1:0]  ent_asid_i [ENTRIES],
    input  logic [ENTRIES-1:0] ent_g_i,
    input  logic [18:0]        vpn2_i,
    input  logic [ASID_W-1:0]  asid_i,
    output logic               hit_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [ENTRIES-1:0] w_match;

    // Per-entry compare: tag equal and (global or same address space).
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
        assign w_match[gi] = (ent_vpn2_i[gi] == vpn2_i) &&
                             (ent_g_i[gi] || (ent_asid_i[gi] == asid_i));
    end

    // Priority encode; scanning downward leaves the lowest matching index.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule : tlb_match
`default_nettype wire

// File: rtl/mmu_tlb.sv
`default_nettype none
// ============================================================================
//  Module   : mmu_tlb
//  Purpose  : One-port address translation: kseg0/kseg1 direct mapped,
//             other segments through a fully-associative even/odd-pair TLB.
//             Single registered lookup stage with valid/ready handshake,
//             CP0 write/read/probe ports.
//  Revision : 1.0 - initial release
// ============================================================================
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int          TLB_ENTRIES  = 16,
    parameter int          ASID_W       = 8,
    parameter logic [15:0] UNCACHE_HI16 = 16'hBFAF,
    parameter bit          K0_UNCACHED  = 1'b0,
    parameter bit          USE_TLB      = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_vaddr,
    input  logic                           req_store,
    input  logic [ASID_W-1:0]              cur_asid,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_paddr,
    output logic                           rsp_uncached,
    output mmu_exc_t                       rsp_exc,
    input  logic                           tlb_we,
    input  logic [$clog2(TLB_ENTRIES)-1:0] tlb_widx,
    input  tlb_entry_t                     tlb_wdata,
    input  logic [$clog2(TLB_ENTRIES)-1:0] tlb_ridx,
    output tlb_entry_t                     tlb_rdata,
    input  logic                           tlbp_valid,
    input  logic [18:0]                    tlbp_vpn2,
    input  logic [ASID_W-1:0]              tlbp_asid,
    output logic                           tlbp_hit,
    output logic [$clog2(TLB_ENTRIES)-1:0] tlbp_idx
);

    localparam int IDX_W = $clog2(TLB_ENTRIES);

    tlb_entry_t              entries_q [TLB_ENTRIES];
    logic [18:0]             w_key_vpn2 [TLB_ENTRIES];
    logic [ASID_W-1:0]       w_key_asid [TLB_ENTRIES];
    logic [TLB_ENTRIES-1:0]  w_key_g;

    logic                    w_lk_hit;
    logic [IDX_W-1:0]        w_lk_idx;
    logic                    w_pb_hit;
    logic [IDX_W-1:0]        w_pb_idx;

    logic                    w_accept;
    logic [2:0]              w_seg;
    logic                    w_win;
    logic                    w_odd;
    logic [19:0]             w_pfn;
    logic [2:0]              w_c;
    logic                    w_d;
    logic                    w_v;
    logic [31:0]             w_paddr;
    logic                    w_unc;
    mmu_exc_t                w_exc;

    logic                    rsp_valid_q;
    logic [31:0]             rsp_paddr_q;
    logic                    rsp_unc_q;
    mmu_exc_t                rsp_exc_q;
    logic                    tlbp_hit_q;
    logic [IDX_W-1:0]        tlbp_idx_q;

    // Tag fields broken out so both match instances share one key view.
    for (genvar gi = 0; gi < TLB_ENTRIES; gi++) begin : g_keys
        assign w_key_vpn2[gi] = entries_q[gi].vpn2;
        assign w_key_asid[gi] = entries_q[gi].asid[ASID_W-1:0];
        assign w_key_g[gi]    = entries_q[gi].g;
    end

    tlb_match #(
        .ENTRIES (TLB_ENTRIES),
        .ASID_W  (ASID_W),
        .IDX_W   (IDX_W)
    ) u_match_lookup (
        .ent_vpn2_i (w_key_vpn2),
        .ent_asid_i (w_key_asid),
        .ent_g_i    (w_key_g),
        .vpn2_i     (req_vaddr[31:13]),
        .asid_i     (cur_asid),
        .hit_o      (w_lk_hit),
        .idx_o      (w_lk_idx)
    );

    tlb_match #(
        .ENTRIES (TLB_ENTRIES),
        .ASID_W  (ASID_W),
        .IDX_W   (IDX_W)
    ) u_match_probe (
        .ent_vpn2_i (w_key_vpn2),
        .ent_asid_i (w_key_asid),
        .ent_g_i    (w_key_g),
        .vpn2_i     (tlbp_vpn2),
        .asid_i     (tlbp_asid),
        .hit_o      (w_pb_hit),
        .idx_o      (w_pb_idx)
    );

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign w_accept  = req_valid && req_ready;
    assign tlb_rdata = entries_q[tlb_ridx];

    // Entry storage; a same-cycle lookup or probe sees the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else if (tlb_we) begin
            entries_q[tlb_widx] <= tlb_wdata;
        end
    end

    // Segment decode, page-pair select and fault classification.
    always_comb begin
        w_seg   = req_vaddr[31:29];
        w_win   = (req_vaddr[31:16] == UNCACHE_HI16);
        w_odd   = req_vaddr[12];
        w_pfn   = w_odd ? entries_q[w_lk_idx].pfn1 : entries_q[w_lk_idx].pfn0;
        w_c     = w_odd ? entries_q[w_lk_idx].c1   : entries_q[w_lk_idx].c0;
        w_d     = w_odd ? entries_q[w_lk_idx].d1   : entries_q[w_lk_idx].d0;
        w_v     = w_odd ? entries_q[w_lk_idx].v1   : entries_q[w_lk_idx].v0;
        w_paddr = '0;
        w_unc   = w_win;
        w_exc   = EXC_NONE;
        if (w_seg == SEG_KSEG0) begin
            w_paddr = req_vaddr - KSEG0_BASE;
            w_unc   = K0_UNCACHED | w_win;
        end else if (w_seg == SEG_KSEG1) begin
            w_paddr = req_vaddr - KSEG1_BASE;
            w_unc   = 1'b1;
        end else if (!USE_TLB) begin
            w_paddr = req_vaddr;
        end else if (!w_lk_hit) begin
            w_exc   = EXC_REFILL;
        end else begin
            w_unc = (w_c == CACHE_UNCACHED) || w_win;
            if (!w_v) begin
                w_exc = EXC_INVALID;
            end else if (req_store && !w_d) begin
                w_exc = EXC_MODIFIED;
            end else begin
                w_paddr = {w_pfn, req_vaddr[11:0]};
            end
        end
    end

    // Response stage: load on accept, hold while stalled, flush drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_paddr_q <= '0;
            rsp_unc_q   <= 1'b0;
            rsp_exc_q   <= EXC_NONE;
        end else if (flush) begin
            rsp_valid_q <= 1'b0;
        end else if (w_accept) begin
            rsp_valid_q <= 1'b1;
            rsp_paddr_q <= w_paddr;
            rsp_unc_q   <= w_unc;
            rsp_exc_q   <= w_exc;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Probe result register, held until the next probe request.
    always_ff @(posedge clk) begin
        if (rst) begin
            tlbp_hit_q <= 1'b0;
            tlbp_idx_q <= '0;
        end else if (tlbp_valid) begin
            tlbp_hit_q <= w_pb_hit;
            tlbp_idx_q <= w_pb_hit ? w_pb_idx : '0;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_paddr    = rsp_paddr_q;
    assign rsp_uncached = rsp_unc_q;
    assign rsp_exc      = rsp_exc_q;
    assign tlbp_hit     = tlbp_hit_q;
    assign tlbp_idx     = tlbp_idx_q;

endmodule : mmu_tlb
`default_nettype wire

// File: tb/tb_mmu_tlb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmu_tlb
//  Purpose  : Self-checking bench for mmu_tlb: directed scenarios followed by
//             randomized traffic against a behavioural translation model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmu_tlb;
    import mmu_pkg::*;

    localparam int N  = 16;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic [31:0]      req_vaddr = '0;
    logic             req_store = 1'b0;
    logic [7:0]       cur_asid = '0;
    logic             rsp_ready = 1'b1;
    logic             tlb_we = 1'b0;
    logic [IW-1:0]    tlb_widx = '0;
    tlb_entry_t       tlb_wdata = '0;
    logic [IW-1:0]    tlb_ridx = '0;
    logic             tlbp_valid = 1'b0;
    logic [18:0]      tlbp_vpn2 = '0;
    logic [7:0]       tlbp_asid = '0;

    logic             req_ready, rsp_valid, rsp_uncached, tlbp_hit;
    logic [31:0]      rsp_paddr;
    mmu_exc_t         rsp_exc;
    tlb_entry_t       tlb_rdata;
    logic [IW-1:0]    tlbp_idx;

    logic             w2_req_ready, w2_rsp_valid, w2_rsp_uncached, w2_tlbp_hit;
    logic [31:0]      w2_rsp_paddr;
    mmu_exc_t         w2_rsp_exc;
    tlb_entry_t       w2_tlb_rdata;
    logic [IW-1:0]    w2_tlbp_idx;

    always #5 clk = ~clk;

    mmu_tlb #(.TLB_ENTRIES(N), .ASID_W(8), .UNCACHE_HI16(16'hBFAF),
              .K0_UNCACHED(1'b0), .USE_TLB(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_store(req_store), .cur_asid(cur_asid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_paddr(rsp_paddr),
        .rsp_uncached(rsp_uncached), .rsp_exc(rsp_exc),
        .tlb_we(tlb_we), .tlb_widx(tlb_widx), .tlb_wdata(tlb_wdata),
        .tlb_ridx(tlb_ridx), .tlb_rdata(tlb_rdata),
        .tlbp_valid(tlbp_valid), .tlbp_vpn2(tlbp_vpn2), .tlbp_asid(tlbp_asid),
        .tlbp_hit(tlbp_hit), .tlbp_idx(tlbp_idx)
    );

    // Second instance with the uncached window moved into kseg0.
    mmu_tlb #(.TLB_ENTRIES(N), .ASID_W(8), .UNCACHE_HI16(16'h9FAF),
              .K0_UNCACHED(1'b0), .USE_TLB(1'b1)) u_dut_win (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(w2_req_ready), .req_vaddr(req_vaddr),
        .req_store(req_store), .cur_asid(cur_asid),
        .rsp_valid(w2_rsp_valid), .rsp_ready(rsp_ready), .rsp_paddr(w2_rsp_paddr),
        .rsp_uncached(w2_rsp_uncached), .rsp_exc(w2_rsp_exc),
        .tlb_we(tlb_we), .tlb_widx(tlb_widx), .tlb_wdata(tlb_wdata),
        .tlb_ridx(tlb_ridx), .tlb_rdata(w2_tlb_rdata),
        .tlbp_valid(tlbp_valid), .tlbp_vpn2(tlbp_vpn2), .tlbp_asid(tlbp_asid),
        .tlbp_hit(w2_tlbp_hit), .tlbp_idx(w2_tlbp_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    tlb_entry_t  m_tlb [N];
    logic        m_valid;
    logic [31:0] m_paddr;
    logic        m_unc;
    logic [1:0]  m_exc;
    logic        m_phit;
    logic [IW-1:0] m_pidx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int model_find(input logic [18:0] vpn2, input logic [7:0] asid);
        for (int i = 0; i < N; i++) begin
            if (m_tlb[i].vpn2 == vpn2 && (m_tlb[i].g || m_tlb[i].asid == asid))
                return i;
        end
        return -1;
    endfunction

    // Translation as the architecture defines it.
    task automatic model_xlate(input logic [31:0] va, input logic st, input logic [7:0] asid,
                               output logic [31:0] pa, output logic unc, output logic [1:0] exc);
        int          hit;
        logic        win;
        tlb_entry_t  e;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d, v;
        win = (va[31:16] == 16'hBFAF);
        pa = 32'd0; unc = win; exc = 2'd0;
        if (va[31:29] == 3'b100) begin
            pa = va - 32'h8000_0000;
        end else if (va[31:29] == 3'b101) begin
            pa = va - 32'hA000_0000;
            unc = 1'b1;
        end else begin
            hit = model_find(va[31:13], asid);
            if (hit < 0) begin
                exc = 2'd1;
            end else begin
                e   = m_tlb[hit];
                pfn = va[12] ? e.pfn1 : e.pfn0;
                c   = va[12] ? e.c1 : e.c0;
                d   = va[12] ? e.d1 : e.d0;
                v   = va[12] ? e.v1 : e.v0;
                unc = (c == 3'd2) || win;
                if (!v)              exc = 2'd2;
                else if (st && !d)   exc = 2'd3;
                else                 pa = {pfn, va[11:0]};
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_tlb[i] = '0;
        m_valid = 1'b0; m_paddr = '0; m_unc = 1'b0; m_exc = 2'd0;
        m_phit = 1'b0; m_pidx = '0;
    endtask

    // One clock: inputs already driven; advance, update model, compare.
    task automatic step();
        logic [31:0] pa;
        logic        unc;
        logic [1:0]  ex;
        int          pi;
        tlb_entry_t  e;
        #1;
        if (!rst) chk("req_ready", req_ready, (!m_valid || rsp_ready));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (flush) begin
                m_valid = 1'b0;
            end else if (req_valid && (!m_valid || rsp_ready)) begin
                model_xlate(req_vaddr, req_store, cur_asid, pa, unc, ex);
                m_valid = 1'b1; m_paddr = pa; m_unc = unc; m_exc = ex;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
            if (tlbp_valid) begin
                pi = model_find(tlbp_vpn2, tlbp_asid);
                m_phit = (pi >= 0);
                m_pidx = (pi >= 0) ? IW'(pi) : '0;
            end
            if (tlb_we) m_tlb[tlb_widx] = tlb_wdata;
        end
        @(negedge clk);
        chk("rsp_valid", rsp_valid, m_valid);
        if (m_valid) begin
            chk("rsp_paddr", rsp_paddr, m_paddr);
            chk("rsp_exc", rsp_exc, m_exc);
            if (m_exc == 2'd0) chk("rsp_uncached", rsp_uncached, m_unc);
        end
        chk("tlbp_hit", tlbp_hit, m_phit);
        chk("tlbp_idx", tlbp_idx, m_pidx);
        e = m_tlb[tlb_ridx];
        chk("rdata_lo", tlb_rdata[31:0], e[31:0]);
        chk("rdata_mid", tlb_rdata[63:32], e[63:32]);
        chk("rdata_hi", 32'(tlb_rdata[77:64]), 32'(e[77:64]));
    endtask

    task automatic do_req(input logic [31:0] va, input logic st, input logic [7:0] asid);
        req_valid = 1'b1; req_vaddr = va; req_store = st; cur_asid = asid;
        step();
        req_valid = 1'b0; req_store = 1'b0;
    endtask

    task automatic do_wr(input int idx, input tlb_entry_t e);
        tlb_we = 1'b1; tlb_widx = IW'(idx); tlb_wdata = e;
        step();
        tlb_we = 1'b0;
    endtask

    function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                                      input logic [19:0] pfn1, input logic [2:0] c1,
                                      input logic d1, input logic v1);
        tlb_entry_t e;
        e = '0;
        e.vpn2 = vpn2; e.asid = asid; e.g = g;
        e.pfn1 = pfn1; e.c1 = c1; e.d1 = d1; e.v1 = v1;
        return e;
    endfunction

    function automatic logic [18:0] pool_vpn2(input int k);
        case (k)
            0:       return 19'h00200;
            1:       return 19'h00201;
            2:       return 19'h60000;
            default: return 19'h7FFFF;
        endcase
    endfunction

    function automatic logic [31:0] rand_vaddr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 7);
        if (k == 0)      return {3'b100, r[28:0]};
        else if (k == 1) return {3'b101, r[28:0]};
        else             return {pool_vpn2($urandom_range(0, 3)), r[12:0]};
    endfunction

    initial begin
        tlb_entry_t e;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_rsp_paddr", rsp_paddr, 32'd0);
        chk("rst_rsp_unc", rsp_uncached, 32'd0);
        chk("rst_rsp_exc", rsp_exc, EXC_NONE);
        chk("rst_tlbp_hit", tlbp_hit, 32'd0);
        chk("rst_tlbp_idx", tlbp_idx, 32'd0);

        // Direct-mapped segments
        do_req(32'hBFC0_0000, 1'b0, 8'd0);
        chk("kseg1_paddr", rsp_paddr, 32'h1FC0_0000);
        chk("kseg1_unc", rsp_uncached, 32'd1);
        chk("kseg1_exc", rsp_exc, EXC_NONE);
        do_req(32'h8000_1234, 1'b0, 8'd0);
        chk("kseg0_paddr", rsp_paddr, 32'h0000_1234);
        chk("kseg0_unc", rsp_uncached, 32'd0);

        // Peripheral window
        do_req(32'hBFAF_F000, 1'b0, 8'd0);
        chk("win_paddr", rsp_paddr, 32'h1FAF_F000);
        chk("win_unc", rsp_uncached, 32'd1);
        do_req(32'h9FAF_0010, 1'b0, 8'd0);
        chk("k0win_unc_default", rsp_uncached, 32'd0);
        chk("k0win_valid", w2_rsp_valid, 32'd1);
        chk("k0win_paddr", w2_rsp_paddr, 32'h1FAF_0010);
        chk("k0win_unc", w2_rsp_uncached, 32'd1);

        // Write idx 3 with a same-cycle lookup and probe: both see old contents
        e = mk(19'h00200, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1);
        tlbp_valid = 1'b1; tlbp_vpn2 = 19'h00200; tlbp_asid = 8'd5;
        req_valid = 1'b1; req_vaddr = 32'h0040_1ABC; cur_asid = 8'd5;
        tlb_ridx = 4'd3;
        do_wr(3, e);
        req_valid = 1'b0;
        chk("wr_same_cycle_exc", rsp_exc, EXC_REFILL);
        chk("probe_old_hit", tlbp_hit, 32'd0);

        // Following request and probe hit
        do_req(32'h0040_1ABC, 1'b0, 8'd5);
        tlbp_valid = 1'b0;
        chk("hit_paddr", rsp_paddr, 32'h1234_5ABC);
        chk("hit_exc", rsp_exc, EXC_NONE);
        chk("probe_hit", tlbp_hit, 32'd1);
        chk("probe_idx", tlbp_idx, 32'd3);
        chk("rdata_vpn2", tlb_rdata.vpn2, 32'h00200);
        do_req(32'h0040_1ABC, 1'b0, 8'd6);
        chk("asid_miss_exc", rsp_exc, EXC_REFILL);
        chk("asid_miss_paddr", rsp_paddr, 32'd0);

        // Faults on the same entry
        do_wr(3, mk(19'h00200, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b0));
        do_req(32'h0040_1ABC, 1'b0, 8'd5);
        chk("invalid_exc", rsp_exc, EXC_INVALID);
        chk("invalid_paddr", rsp_paddr, 32'd0);
        do_wr(3, mk(19'h00200, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b0, 1'b1));
        do_req(32'h0040_1ABC, 1'b1, 8'd5);
        chk("modified_exc", rsp_exc, EXC_MODIFIED);
        do_req(32'h0040_1ABC, 1'b0, 8'd5);
        chk("load_exc", rsp_exc, EXC_NONE);
        chk("load_paddr", rsp_paddr, 32'h1234_5ABC);

        // Stall for 3 cycles
        do_req(32'h8000_0040, 1'b0, 8'd0);
        rsp_ready = 1'b0; req_valid = 1'b1; req_vaddr = 32'h8000_0080;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_paddr", rsp_paddr, 32'h0000_0040);
            chk("stall_valid", rsp_valid, 32'd1);
            chk("stall_ready", req_ready, 32'd0);
        end
        // Flush while stalled, then flush with a same-cycle accept
        flush = 1'b1;
        step();
        chk("flush_valid", rsp_valid, 32'd0);
        rsp_ready = 1'b1;
        step();
        chk("flush_accept_valid", rsp_valid, 32'd0);
        flush = 1'b0; req_valid = 1'b0;

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req_valid  = ($urandom_range(0, 3) != 0);
            req_vaddr  = rand_vaddr();
            req_store  = $urandom_range(0, 1) == 1;
            cur_asid   = 8'($urandom_range(0, 3));
            flush      = ($urandom_range(0, 31) == 0);
            tlb_ridx   = IW'($urandom_range(0, N - 1));
            tlb_we     = ($urandom_range(0, 7) == 0);
            tlb_widx   = IW'($urandom_range(0, N - 1));
            e          = tlb_entry_t'({$urandom, $urandom, $urandom});
            e.vpn2     = pool_vpn2($urandom_range(0, 3));
            e.asid     = 8'($urandom_range(0, 3));
            e.g        = ($urandom_range(0, 3) == 0);
            tlb_wdata  = e;
            tlbp_valid = ($urandom_range(0, 3) == 0);
            tlbp_vpn2  = pool_vpn2($urandom_range(0, 3));
            tlbp_asid  = 8'($urandom_range(0, 3));
            step();
        end
        flush = 1'b0; tlb_we = 1'b0; req_valid = 1'b0; tlbp_valid = 1'b0;
        rsp_ready = 1'b1;
        step();

        // Reset mid-stall
        do_wr(3, mk(19'h00200, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1));
        tlbp_valid = 1'b1; tlbp_vpn2 = 19'h00200; tlbp_asid = 8'd5;
        do_req(32'hA000_0100, 1'b0, 8'd0);
        tlbp_valid = 1'b0;
        chk("pre_rst_hit", tlbp_hit, 32'd1);
        rsp_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        chk("midrst_valid", rsp_valid, 32'd0);
        chk("midrst_paddr", rsp_paddr, 32'd0);
        chk("midrst_unc", rsp_uncached, 32'd0);
        chk("midrst_exc", rsp_exc, EXC_NONE);
        chk("midrst_phit", tlbp_hit, 32'd0);
        chk("midrst_pidx", tlbp_idx, 32'd0);
        do_req(32'h0040_1ABC, 1'b0, 8'd5);
        chk("post_rst_exc", rsp_exc, EXC_REFILL);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mmu_tlb
`default_nettype wire

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
Address-translation unit for one memory port (instruction or data). Replaces the fixed-segment mapper: kseg0/kseg1 stay direct-mapped, while kuseg/kseg2/kseg3 translate through a parametrised fully-associative MIPS-style TLB with even/odd page pairs. It has one registered lookup stage with a valid/ready handshake, plus CP0-facing write (TLBWI/TLBWR) and probe (TLBP) ports. It sits between address generation and the cache/uncached bridge.

Parameters:
TLB_ENTRIES, 16, number of entries; power of two, 2..64
ASID_W, 8, ASID width
UNCACHE_HI16, 16'hBFAF, vaddr[31:16] forced uncached (peripheral window)
K0_UNCACHED, 0, 1 = kseg0 treated as uncached
USE_TLB, 1, 0 = mapped segments pass through identity, never fault

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  drop the registered response
req_valid  in  1  translation request
req_ready  out  1  request accepted this cycle when high with req_valid
req_vaddr  in  32  virtual address
req_store  in  1  request is a store
cur_asid  in  ASID_W  current EntryHi.ASID
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer takes result
rsp_paddr  out  32  physical address
rsp_uncached  out  1  uncached access
rsp_exc  out  2  mmu_exc_t: NONE/REFILL/INVALID/MODIFIED
tlb_we  in  1  write entry
tlb_widx  in  $clog2(TLB_ENTRIES)  write index
tlb_wdata  in  tlb_entry_t  entry written
tlb_ridx  in  $clog2(TLB_ENTRIES)  read index (TLBR)
tlb_rdata  out  tlb_entry_t  combinational read of entry tlb_ridx
tlbp_valid  in  1  probe request
tlbp_vpn2  in  19  probe VPN2
tlbp_asid  in  ASID_W  probe ASID
tlbp_hit  out  1  probe result valid-hit, 1 cycle after tlbp_valid
tlbp_idx  out  $clog2(TLB_ENTRIES)  matching index (0 on miss)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: rsp_valid=0, rsp_paddr=0, rsp_uncached=0, rsp_exc=NONE, tlbp_hit=0, tlbp_idx=0. All entries are cleared to zero (V0=V1=0, G=0). Reset mid-stall discards the pending response.
- Handshake: req_ready = !rsp_valid || rsp_ready. When a request is accepted, the lookup is combinational and the result is registered, so rsp_valid rises the next cycle (latency 1). Back-to-back requests sustain full throughput.
- Stall: while rsp_valid && !rsp_ready, all rsp_* outputs hold and req_ready=0.
- Flush: flush clears rsp_valid next cycle. An accept in the same cycle as flush is dropped.
- Segments, decoded from vaddr[31:29]:
  - 100 (kseg0): paddr = vaddr - 0x8000_0000; uncached = K0_UNCACHED.
  - 101 (kseg1): paddr = vaddr - 0xA000_0000; uncached = 1.
  - All other segments are mapped when USE_TLB=1, and identity with uncached=0 when USE_TLB=0.
  - Direct-mapped segments never fault.
- Uncached override: vaddr[31:16]==UNCACHE_HI16 forces uncached=1 regardless of segment.
- Match rule: entry i matches when vpn2==vaddr[31:13] and (G || asid==cur_asid). Page select is vaddr[12]: 0 uses pfn0/c0/d0/v0, 1 uses pfn1/c1/d1/v1.
- Translation result: paddr = {pfn[19:0], vaddr[11:0]}; uncached = (c==3'd2) or the window override.
- Exception priority:
  - No match -> REFILL.
  - Match with v=0 -> INVALID.
  - req_store and d=0 -> MODIFIED.
  - Otherwise NONE.
  - On any exception, rsp_paddr = 0.
- Multiple matches: the lowest index wins (software error, but deterministic).
- Write: tlb_we updates entry tlb_widx at the clock edge. A lookup accepted in the same cycle sees the old contents. The write is visible from the next accept.
- Probe: same match rule as lookup, using tlbp_asid, with lowest index winning. Registered and independent of the request path; it may coincide with a lookup. A probe coinciding with tlb_we sees the old contents.
- tlbp_hit and tlbp_idx hold their value until the next tlbp_valid.

Decomposition:
- Package mmu_pkg holds:
  - tlb_entry_t, packed: vpn2[18:0], asid, g, pfn0[19:0], c0[2:0], d0, v0, pfn1, c1, d1, v1.
  - mmu_exc_t enum.
  - Segment constants: KSEG0_BASE, KSEG1_BASE, SEG_KSEG0=3'b100, SEG_KSEG1=3'b101.
  - CACHE_UNCACHED=3'd2.
- One sub-module, tlb_match: combinational parallel compare plus priority encoder (vpn2, asid -> hit, idx). It is instantiated twice, once for lookup and once for probe.

Test Plan:
- Direct-mapped segments: req 0xBFC0_0000 -> next cycle rsp_paddr=0x1FC0_0000, uncached=1, exc=NONE. Req 0x8000_1234 -> 0x0000_1234, uncached=0.
- Peripheral window: req 0xBFAF_F000 -> paddr 0x1FAF_F000, uncached=1. With UNCACHE_HI16 window set inside kseg0 (0x9FAF), req 0x9FAF_0010 -> uncached=1.
- Mapped hit: write idx 3 with vpn2=0x00200, asid=5, g=0, pfn1=0x12345, c1=3, d1=1, v1=1; cur_asid=5; req 0x0040_1ABC -> paddr 0x1234_5ABC, exc NONE. cur_asid=6 -> REFILL.
- Faults on the same entry:
  - v1=0 -> INVALID.
  - v1=1, d1=0 with req_store=1 -> MODIFIED.
  - The same load -> NONE.
- Ordering: tlb_we and req in the same cycle -> old result (REFILL); the following req hits. Probe vpn2=0x00200/asid 5 -> tlbp_hit=1, tlbp_idx=3 one cycle later.
- Control flow:
  - Hold rsp_ready=0 for 3 cycles -> outputs stable, req_ready=0.
  - Assert flush -> rsp_valid=0 next cycle.
  - Assert rst mid-stall -> all outputs reset and the TLB cleared (subsequent mapped req -> REFILL).
